// File: rtl/nes_pad_reader_if.sv
// nes_pad_reader_if: bundles the NES pad reader's control, pad-pin and decoded-button signals.
// Latency: none; wires only.
// Backpressure: none; every signal is a plain level or a one-cycle pulse.
//
// Ports (no clock/reset here; those stay scalar on the reader):
//   enable, poll_now, pad_data[1:0]          host/pins -> reader
//   pad_latch, pad_clk, joy0, joy1, present,
//   valid                                    reader -> pins/host
// master = reader side, slave = host/pin side.
interface nes_pad_reader_if;
  logic       enable;
  logic       poll_now;
  logic [1:0] pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] joy0;
  logic [7:0] joy1;
  logic [1:0] present;
  logic       valid;

  modport master (
    input  enable, poll_now, pad_data,
    output pad_latch, pad_clk, joy0, joy1, present, valid
  );

  modport slave (
    output enable, poll_now, pad_data,
    input  pad_latch, pad_clk, joy0, joy1, present, valid
  );
endinterface

// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls two NES (4021) pads and decodes them into active-high button words.
// Latency: joy0/joy1/present/valid update LATCH_CYC + 17*HALF_CYC + 1 clocks after a request is accepted.
// Backpressure: none; poll ticks and poll_now seen outside IDLE are dropped, never queued.
//
// Ports:
//   CLK_50M          clock
//   reset            synchronous, active-high
//   bus (master)     enable, poll_now, pad_data[1:0] in (pins active-low, asynchronous);
//                    pad_latch, pad_clk (idle high), joy0/joy1 (bit0 A .. bit7 Right),
//                    present[1:0], valid (one-cycle pulse) out
// HALF_CYC must be at least 3 so the two-flop input synchronizer settles before each sample.
module nes_pad_reader #(
  parameter int LATCH_CYC = 600,
  parameter int HALF_CYC  = 300,
  parameter int POLL_CYC  = 833333
) (
  input logic              CLK_50M,
  input logic              reset,
  nes_pad_reader_if.master bus
);

  localparam int PW     = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
  localparam int PH_MAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int HW     = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [HW-1:0] LATCH_LAST = HW'(LATCH_CYC - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP,
    S_CLK_LO,
    S_CLK_HI,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------
  // Input synchronizer; everything downstream uses data_sync only.
  // ---------------------------------------------------------------
  logic [1:0] data_meta;
  logic [1:0] data_sync;
  logic [1:0] pressed;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      data_meta <= '0;
      data_sync <= '0;
    end else begin
      data_meta <= bus.pad_data;
      data_sync <= data_meta;
    end
  end

  // Pad pins are active-low: a low pin is a pressed button (or the presence bit).
  assign pressed = ~data_sync;

  // ---------------------------------------------------------------
  // Poll counter: free-running, restarted by every frame start.
  // ---------------------------------------------------------------
  state_t          state;
  logic [PW-1:0]   poll_cnt;
  logic            poll_tick;
  logic            frame_start;

  assign poll_tick   = (poll_cnt == POLL_LAST);
  // A tick coinciding with poll_now still yields a single frame.
  assign frame_start = (state == S_IDLE) && bus.enable && (poll_tick || bus.poll_now);

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (frame_start || poll_tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + PW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Frame sequencer with registered pin and result outputs.
  // ---------------------------------------------------------------
  logic [HW-1:0] phase;
  logic [3:0]    bit_idx;
  logic [8:0]    bits0;
  logic [8:0]    bits1;
  logic          latch_q;
  logic          clk_q;
  logic          valid_q;
  logic [7:0]    joy0_q;
  logic [7:0]    joy1_q;
  logic [1:0]    present_q;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= '0;
      bit_idx   <= '0;
      bits0     <= '0;
      bits1     <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b1;
      valid_q   <= 1'b0;
      joy0_q    <= '0;
      joy1_q    <= '0;
      present_q <= '0;
    end else begin
      valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          phase <= '0;
          if (!bus.enable) begin
            joy0_q    <= '0;
            joy1_q    <= '0;
            present_q <= '0;
          end
          if (frame_start) begin
            latch_q <= 1'b1;
            state   <= S_LATCH;
          end
        end

        S_LATCH: begin
          if (phase == LATCH_LAST) begin
            phase   <= '0;
            latch_q <= 1'b0;
            state   <= S_GAP;
          end else begin
            phase <= phase + HW'(1);
          end
        end

        // The pads present bit 0 (A) as soon as they are latched, so it is
        // read at the end of the gap before any clock pulse.
        S_GAP: begin
          if (phase == HALF_LAST) begin
            phase    <= '0;
            bits0[0] <= pressed[0];
            bits1[0] <= pressed[1];
            bit_idx  <= 4'd1;
            clk_q    <= 1'b0;
            state    <= S_CLK_LO;
          end else begin
            phase <= phase + HW'(1);
          end
        end

        S_CLK_LO: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            clk_q <= 1'b1;
            state <= S_CLK_HI;
          end else begin
            phase <= phase + HW'(1);
          end
        end

        // Sample at the end of the high half so the shifted bit has had
        // HALF_CYC clocks to cross the synchronizer.
        S_CLK_HI: begin
          if (phase == HALF_LAST) begin
            phase          <= '0;
            bits0[bit_idx] <= pressed[0];
            bits1[bit_idx] <= pressed[1];
            if (bit_idx < 4'd8) begin
              bit_idx <= bit_idx + 4'd1;
              clk_q   <= 1'b0;
              state   <= S_CLK_LO;
            end else begin
              // Bit 8 is the presence bit being sampled right now: a real pad
              // has shifted in its grounded serial input (pin low), an empty
              // port floats high. Decode from it directly so the words and
              // valid are all visible during the DONE cycle.
              present_q <= pressed;
              joy0_q    <= pressed[0] ? bits0[7:0] : 8'h00;
              joy1_q    <= pressed[1] ? bits1[7:0] : 8'h00;
              valid_q   <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            phase <= phase + HW'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pad_latch = latch_q;
  assign bus.pad_clk   = clk_q;
  assign bus.joy0      = joy0_q;
  assign bus.joy1      = joy1_q;
  assign bus.present   = present_q;
  assign bus.valid     = valid_q;

endmodule
